// File: rtl/combination_sender.sv
// Combination-lock transmitter: serializes a code MSB-first as zero/one pulses,
// then waits for the lock's unlock level and reports pass/fail with a timeout.
module combination_sender #(
  parameter int CODE_W  = 8,
  parameter int GAP     = 2,
  parameter int TIMEOUT = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [CODE_W-1:0] code,
  input  logic [3:0]        len,
  input  logic              unlock,
  output logic              zero,
  output logic              one,
  output logic              busy,
  output logic              done,
  output logic              success
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEND,
    S_GAP,
    S_WAIT,
    S_DONE
  } state_t;

  localparam logic [4:0] CW       = 5'(CODE_W);
  localparam logic [3:0] GAP_LAST = 4'(GAP - 1);
  localparam logic [7:0] TO_LAST  = 8'(TIMEOUT - 1);
  localparam bit         HAS_GAP  = (GAP > 0);

  state_t            state_q, state_d;
  logic [CODE_W-1:0] code_q, code_d;
  logic [3:0]        len_q, len_d;
  logic [3:0]        idx_q, idx_d;
  logic [3:0]        gcnt_q, gcnt_d;
  logic [7:0]        wcnt_q, wcnt_d;
  logic              zero_q, zero_d;
  logic              one_q, one_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              success_q, success_d;

  logic [15:0] in_ext;
  logic [15:0] q_ext;
  logic        len_ok;
  logic        last;
  logic [3:0]  first_pos;
  logic [3:0]  cur_pos;
  logic [3:0]  nxt_pos;

  assign in_ext    = 16'(code);
  assign q_ext     = 16'(code_q);
  assign len_ok    = (len != 4'd0) && ({1'b0, len} <= CW);
  assign last      = (idx_q == len_q - 4'd1);
  assign first_pos = len - 4'd1;
  assign cur_pos   = len_q - idx_q - 4'd1;
  assign nxt_pos   = len_q - idx_q - 4'd2;

  // Pulses are registered, so each one is decided on the edge entering SEND.
  always_comb begin
    state_d   = state_q;
    code_d    = code_q;
    len_d     = len_q;
    idx_d     = idx_q;
    gcnt_d    = gcnt_q;
    wcnt_d    = wcnt_q;
    zero_d    = 1'b0;
    one_d     = 1'b0;
    done_d    = 1'b0;
    success_d = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          code_d = code;
          len_d  = len;
          idx_d  = 4'd0;
          gcnt_d = 4'd0;
          wcnt_d = 8'd0;
          if (len_ok) begin
            state_d = S_SEND;
            one_d   = in_ext[first_pos];
            zero_d  = !in_ext[first_pos];
          end else begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end
        end
      end
      S_SEND: begin
        if (last) begin
          state_d = S_WAIT;
          wcnt_d  = 8'd0;
        end else begin
          idx_d = idx_q + 4'd1;
          if (HAS_GAP) begin
            state_d = S_GAP;
            gcnt_d  = 4'd0;
          end else begin
            one_d  = q_ext[nxt_pos];
            zero_d = !q_ext[nxt_pos];
          end
        end
      end
      S_GAP: begin
        if (gcnt_q == GAP_LAST) begin
          state_d = S_SEND;
          one_d   = q_ext[cur_pos];
          zero_d  = !q_ext[cur_pos];
        end else begin
          gcnt_d = gcnt_q + 4'd1;
        end
      end
      S_WAIT: begin
        if (unlock) begin
          state_d   = S_DONE;
          done_d    = 1'b1;
          success_d = 1'b1;
        end else if (wcnt_q == TO_LAST) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else begin
          wcnt_d = wcnt_q + 8'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      code_q    <= '0;
      len_q     <= 4'd0;
      idx_q     <= 4'd0;
      gcnt_q    <= 4'd0;
      wcnt_q    <= 8'd0;
      zero_q    <= 1'b0;
      one_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      success_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      code_q    <= code_d;
      len_q     <= len_d;
      idx_q     <= idx_d;
      gcnt_q    <= gcnt_d;
      wcnt_q    <= wcnt_d;
      zero_q    <= zero_d;
      one_q     <= one_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      success_q <= success_d;
    end
  end

  assign zero    = zero_q;
  assign one     = one_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign success = success_q;

endmodule

// File: tb/tb_combination_sender.sv
// Bench for combination_sender: two instances (GAP=2 and GAP=0), directed
// table plus randomized attempts checked cycle by cycle against a schedule model.
module tb_combination_sender;

  localparam int M_NONE  = 0;
  localparam int M_LOCK  = 1;
  localparam int M_EARLY = 2;
  localparam int M_RAND  = 3;
  localparam int TO      = 8;

  logic       clk;
  logic       rst;
  logic       st [2];
  logic [7:0] cd [2];
  logic [3:0] ln [2];
  logic       ul [2];
  logic       zo [2];
  logic       on [2];
  logic       bz [2];
  logic       dn [2];
  logic       sc [2];

  int checks;
  int failures;
  bit ucyc [0:63];
  bit scyc [0:63];

  combination_sender #(.CODE_W(8), .GAP(2), .TIMEOUT(TO)) u_g2 (
    .clk(clk), .rst(rst), .start(st[0]), .code(cd[0]), .len(ln[0]),
    .unlock(ul[0]), .zero(zo[0]), .one(on[0]), .busy(bz[0]),
    .done(dn[0]), .success(sc[0])
  );

  combination_sender #(.CODE_W(8), .GAP(0), .TIMEOUT(TO)) u_g0 (
    .clk(clk), .rst(rst), .start(st[1]), .code(cd[1]), .len(ln[1]),
    .unlock(ul[1]), .zero(zo[1]), .one(on[1]), .busy(bz[1]),
    .done(dn[1]), .success(sc[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [4:0] outs(input int s);
    return {zo[s], on[s], bz[s], dn[s], sc[s]};
  endfunction

  task automatic chk(input string name, input int cyc, input int got,
                     input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%0h exp=%0h", name, cyc, got, exp);
    end
  endtask

  // Model: symbol k at cycle 1+k*(G+1); wait window L+1..L+TO.
  task automatic run_attempt(input int sel, input logic [7:0] c,
                             input int l, input int umode, input bit sb,
                             output int act_d, output bit act_s);
    int  g;
    int  lc;
    int  d;
    bit  ok;
    bit  succ;
    bit  ez;
    bit  eo;
    int  k;
    g  = (sel == 0) ? 2 : 0;
    ok = (l >= 1) && (l <= 8);
    lc = ok ? 1 + (l - 1) * (g + 1) : 0;
    for (int i = 0; i < 64; i++) begin
      ucyc[i] = 1'b0;
      scyc[i] = 1'b0;
    end
    case (umode)
      M_LOCK: if (ok && l == 5 && c[4:0] == 5'b01011)
                for (int i = lc + 1; i < 64; i++) ucyc[i] = 1'b1;
      M_EARLY: for (int i = 0; i <= lc; i++) ucyc[i] = 1'b1;
      M_RAND: for (int i = 0; i < 64; i++)
                ucyc[i] = ($urandom_range(0, 5) == 0);
      default: ;
    endcase
    succ = 1'b0;
    if (!ok) begin
      d = 1;
    end else begin
      d = lc + TO + 1;
      for (int w = lc + 1; w <= lc + TO; w++) begin
        if (ucyc[w] && !succ) begin
          succ = 1'b1;
          d    = w + 1;
        end
      end
    end
    if (sb) begin
      if (3 <= d) scyc[3] = 1'b1;
      if (15 <= d) scyc[15] = 1'b1;
      scyc[d] = 1'b1;
    end
    st[sel] = 1'b1;
    cd[sel] = c;
    ln[sel] = 4'(l);
    ul[sel] = ucyc[0];
    @(negedge clk);
    chk("idle", 0, int'(outs(sel)), 0);
    @(posedge clk);
    #1;
    st[sel] = scyc[1];
    cd[sel] = 8'($urandom);
    ln[sel] = 4'($urandom);
    ul[sel] = ucyc[1];
    act_d = -1;
    act_s = 1'b0;
    for (int cy = 1; cy <= d; cy++) begin
      @(negedge clk);
      ez = 1'b0;
      eo = 1'b0;
      if (ok && cy <= lc && ((cy - 1) % (g + 1)) == 0) begin
        k  = (cy - 1) / (g + 1);
        eo = c[l - 1 - k];
        ez = !eo;
      end
      chk("cycle", cy, int'(outs(sel)),
          int'({ez, eo, 1'b1, cy == d, (cy == d) && succ}));
      if (dn[sel] && act_d < 0) begin
        act_d = cy;
        act_s = sc[sel];
      end
      @(posedge clk);
      #1;
      st[sel] = scyc[cy + 1];
      ul[sel] = ucyc[cy + 1];
    end
    st[sel] = 1'b0;
  endtask

  typedef struct {
    int         sel;
    logic [7:0] code;
    int         len;
    int         umode;
    bit         sb;
    int         exp_d;
    bit         exp_s;
  } vec_t;

  vec_t tbl [10];

  initial begin
    int  ad;
    bit  as;
    int  bad;
    checks   = 0;
    failures = 0;
    rst      = 1'b0;
    for (int s = 0; s < 2; s++) begin
      st[s] = 1'b0;
      cd[s] = 8'h00;
      ln[s] = 4'd0;
      ul[s] = 1'b0;
    end
    tbl[0] = '{0, 8'h0B, 5, M_LOCK,  1'b0, 15, 1'b1};
    tbl[1] = '{0, 8'h0A, 5, M_LOCK,  1'b0, 22, 1'b0};
    tbl[2] = '{0, 8'h00, 0, M_NONE,  1'b0, 1,  1'b0};
    tbl[3] = '{0, 8'hFF, 9, M_NONE,  1'b0, 1,  1'b0};
    tbl[4] = '{1, 8'h05, 3, M_NONE,  1'b0, 12, 1'b0};
    tbl[5] = '{0, 8'h0A, 5, M_NONE,  1'b1, 22, 1'b0};
    tbl[6] = '{0, 8'h0B, 5, M_EARLY, 1'b0, 22, 1'b0};
    tbl[7] = '{1, 8'h0B, 5, M_LOCK,  1'b0, 7,  1'b1};
    tbl[8] = '{0, 8'hA5, 8, M_NONE,  1'b0, 31, 1'b0};
    tbl[9] = '{1, 8'h80, 1, M_NONE,  1'b0, 10, 1'b0};

    repeat (2) @(posedge clk);
    #2;
    chk("reset_g2", 0, int'(outs(0)), 0);
    chk("reset_g0", 0, int'(outs(1)), 0);
    rst = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 10; i++) begin
      run_attempt(tbl[i].sel, tbl[i].code, tbl[i].len, tbl[i].umode,
                  tbl[i].sb, ad, as);
      chk($sformatf("tbl%0d_done_cycle", i), i, ad, tbl[i].exp_d);
      chk($sformatf("tbl%0d_success", i), i, int'(as), int'(tbl[i].exp_s));
    end

    st[0] = 1'b1;
    cd[0] = 8'h0B;
    ln[0] = 4'd5;
    ul[0] = 1'b0;
    @(posedge clk);
    #1;
    st[0] = 1'b0;
    repeat (7) @(posedge clk);
    #3;
    chk("pre_rst_gap", 8, int'(outs(0)), int'(5'b00100));
    rst = 1'b0;
    #1;
    chk("rst_async", 8, int'(outs(0)), 0);
    @(posedge clk);
    #2;
    rst = 1'b1;
    bad = 0;
    repeat (30) begin
      @(negedge clk);
      if (outs(0) != 5'b0) bad++;
    end
    chk("quiet_after_rst", 0, bad, 0);
    @(posedge clk);
    #1;
    run_attempt(0, 8'h0B, 5, M_LOCK, 1'b0, ad, as);
    chk("post_rst_done", 0, ad, 15);

    for (int r = 0; r < 40; r++) begin
      run_attempt(int'($urandom_range(0, 1)), 8'($urandom),
                  int'($urandom_range(0, 10)), int'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)), ad, as);
    end

    @(negedge clk);
    chk("final_idle_g2", 0, int'(outs(0)), 0);
    chk("final_idle_g0", 0, int'(outs(1)), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
